// File: rtl/store_commit_buffer.sv
// Store commit buffer: queues committed SB/SH/SW stores from the reorder buffer
// and drains them one byte per granted cycle onto a byte-wide memory port.
module store_commit_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_valid,
  input  logic [5:0]  rob_op_id,
  input  logic [31:0] rob_value,
  input  logic [31:0] rob_addr,
  output logic        scb_full,
  output logic        scb_empty,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_wr,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic        io_buffer_full,
  output logic        err_overflow
);

  // Shared opcode values for the three store flavours.
  localparam logic [5:0] OP_SB = 6'd10;
  localparam logic [5:0] OP_SH = 6'd11;
  localparam logic [5:0] OP_SW = 6'd12;

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_IO_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW:0]     count_q, count_d;
  logic [1:0]      k_q, k_d;
  logic            err_q, err_d;

  logic [31:0]     addr_mem_q [DEPTH];
  logic [31:0]     data_mem_q [DEPTH];
  logic [1:0]      last_mem_q [DEPTH];

  logic            is_store;
  logic [1:0]      in_last;
  logic            push;
  logic            overflow;
  logic            pop;
  logic [PW-1:0]   head_p1;
  logic [31:0]     head_addr;
  logic [31:0]     head_data;
  logic [1:0]      head_last;
  logic [31:0]     next_addr;

  // Stores to the IO region (addr[17:16]==3) wait for UART buffer space first.
  function automatic state_e route(input logic [1:0] region);
    return (region == 2'b11) ? S_IO_WAIT : S_WRITE;
  endfunction

  always_comb begin
    is_store = 1'b0;
    in_last  = 2'd0;
    case (rob_op_id)
      OP_SB: begin is_store = 1'b1; in_last = 2'd0; end
      OP_SH: begin is_store = 1'b1; in_last = 2'd1; end
      OP_SW: begin is_store = 1'b1; in_last = 2'd3; end
      default: begin is_store = 1'b0; in_last = 2'd0; end
    endcase
  end

  assign scb_full  = (count_q == (PW+1)'(DEPTH));
  assign scb_empty = (count_q == '0) && (state_q == S_IDLE);

  assign push     = rdy && rob_valid && is_store && !scb_full;
  assign overflow = rdy && rob_valid && is_store && scb_full;

  assign head_addr = addr_mem_q[head_q];
  assign head_data = data_mem_q[head_q];
  assign head_last = last_mem_q[head_q];
  assign head_p1   = head_q + PW'(1);

  assign mem_req = (state_q == S_WRITE);
  assign mem_wr  = mem_req && mem_gnt && rdy;
  assign pop     = mem_wr && (k_q == head_last);

  // With one entry left, the only possible successor is the store pushed this edge.
  assign next_addr = (count_q > (PW+1)'(1)) ? addr_mem_q[head_p1] : rob_addr;

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    if (mem_req) begin
      mem_a = head_addr + {30'd0, k_q};
      case (k_q)
        2'd0:    mem_dout = head_data[7:0];
        2'd1:    mem_dout = head_data[15:8];
        2'd2:    mem_dout = head_data[23:16];
        default: mem_dout = head_data[31:24];
      endcase
    end
  end

  always_comb begin
    head_d  = pop  ? head_p1 : head_q;
    tail_d  = push ? (tail_q + PW'(1)) : tail_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    err_d   = err_q || overflow;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          k_d = 2'd0;
          if (count_q != '0) state_d = route(head_addr[17:16]);
        end
        S_IO_WAIT: begin
          if (!io_buffer_full) state_d = S_WRITE;
        end
        S_WRITE: begin
          if (mem_wr) begin
            if (pop) begin
              k_d     = 2'd0;
              state_d = (count_d != '0) ? route(next_addr[17:16]) : S_IDLE;
            end else begin
              k_d = k_q + 2'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[tail_q] <= rob_addr;
      data_mem_q[tail_q] <= rob_value;
      last_mem_q[tail_q] <= in_last;
    end
  end

  assign err_overflow = err_q;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: byte-level scoreboard plus literal checks.
module tb_store_commit_buffer;

  localparam int DEPTH = 4;
  localparam logic [5:0] OP_SB = 6'd10;
  localparam logic [5:0] OP_SH = 6'd11;
  localparam logic [5:0] OP_SW = 6'd12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        rob_valid = 1'b0;
  logic [5:0]  rob_op_id = '0;
  logic [31:0] rob_value = '0;
  logic [31:0] rob_addr = '0;
  logic        scb_full;
  logic        scb_empty;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        io_buffer_full = 1'b0;
  logic        err_overflow;

  store_commit_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rob_valid(rob_valid), .rob_op_id(rob_op_id), .rob_value(rob_value), .rob_addr(rob_addr),
    .scb_full(scb_full), .scb_empty(scb_empty),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout),
    .io_buffer_full(io_buffer_full), .err_overflow(err_overflow)
  );

  // clock/reset
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // model: each accepted store expands into its bytes {last, addr, data}
  logic [40:0] exp_q[$];
  int          ent_cnt = 0;
  logic        model_err = 1'b0;
  logic [31:0] wr_a[$];
  logic [7:0]  wr_d[$];
  int          wr_c[$];

  function automatic int nbytes(input logic [5:0] op);
    if (op == OP_SB) return 1;
    if (op == OP_SH) return 2;
    if (op == OP_SW) return 4;
    return 0;
  endfunction

  // scoreboard compare, once per cycle on the falling edge
  always @(negedge clk) begin
    int          cnt0;
    int          nb;
    logic [40:0] e;
    if (!rst) begin
      chk("rst_req",   32'(mem_req), 32'd0);
      chk("rst_wr",    32'(mem_wr), 32'd0);
      chk("rst_a",     mem_a, 32'd0);
      chk("rst_dout",  32'(mem_dout), 32'd0);
      chk("rst_full",  32'(scb_full), 32'd0);
      chk("rst_empty", 32'(scb_empty), 32'd1);
      chk("rst_err",   32'(err_overflow), 32'd0);
      exp_q.delete();
      ent_cnt   = 0;
      model_err = 1'b0;
    end else begin
      chk("full",  32'(scb_full), 32'(ent_cnt == DEPTH));
      chk("empty", 32'(scb_empty), 32'(ent_cnt == 0));
      chk("err",   32'(err_overflow), 32'(model_err));
      if (!mem_req) begin
        chk("noreq_wr",   32'(mem_wr), 32'd0);
        chk("noreq_a",    mem_a, 32'd0);
        chk("noreq_dout", 32'(mem_dout), 32'd0);
      end
      if (!rdy) chk("frozen_wr", 32'(mem_wr), 32'd0);
      cnt0 = ent_cnt;
      if (mem_wr) begin
        wr_a.push_back(mem_a);
        wr_d.push_back(mem_dout);
        wr_c.push_back(cyc_n);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wr_unexpected: got 0x%0h@0x%0h, expected no write", mem_dout, mem_a);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_a, e[39:8]);
          chk("wr_data", 32'(mem_dout), 32'(e[7:0]));
          if (e[40]) ent_cnt--;
        end
      end
      nb = nbytes(rob_op_id);
      if (rdy && rob_valid && nb != 0) begin
        if (cnt0 == DEPTH) model_err = 1'b1;
        else begin
          for (int b = 0; b < nb; b++)
            exp_q.push_back({(b == nb - 1), rob_addr + 32'(b), rob_value[8*b +: 8]});
          ent_cnt++;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    rob_valid = 1'b1;
    rob_op_id = op;
    rob_addr  = a;
    rob_value = d;
    tick();
    rob_valid = 1'b0;
  endtask

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
  endtask

  initial begin
    int pc;
    logic [7:0]  s1_d [4];
    logic [31:0] s5_a [4];
    logic [7:0]  s5_d [4];
    s1_d = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    s5_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    s5_d = '{8'h21, 8'h43, 8'h65, 8'h87};

    #12;
    chk("init_req",   32'(mem_req), 32'd0);
    chk("init_empty", 32'(scb_empty), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // non-store opcode is ignored
    clear_log();
    mem_gnt = 1'b1;
    push(6'd5, 32'h9000, 32'h1111_1111);
    idle(3);
    chk("nonstore_empty", 32'(scb_empty), 32'd1);
    chk("nonstore_nwr", 32'(wr_a.size()), 32'd0);

    // SW, constant grant: four consecutive bytes
    clear_log();
    push(OP_SW, 32'h1000, 32'hAABB_CCDD);
    pc = cyc_n;
    idle(6);
    chk("sw_nwr", 32'(wr_a.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("sw_addr", wr_a[i], 32'h1000 + 32'(i));
      chk("sw_data", 32'(wr_d[i]), 32'(s1_d[i]));
      chk("sw_cyc",  32'(wr_c[i]), 32'(pc + 1 + i));
    end
    chk("sw_empty", 32'(scb_empty), 32'd1);

    // SH with grant 1,0,1
    clear_log();
    mem_gnt = 1'b0;
    push(OP_SH, 32'h2002, 32'h0000_1234);
    pc = cyc_n;
    mem_gnt = 1'b1;
    tick();
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("sh_hold_req",  32'(mem_req), 32'd1);
    chk("sh_hold_wr",   32'(mem_wr), 32'd0);
    chk("sh_hold_a",    mem_a, 32'h2003);
    chk("sh_hold_dout", 32'(mem_dout), 32'h12);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    idle(4);
    chk("sh_nwr",   32'(wr_a.size()), 32'd2);
    chk("sh_a0",    wr_a[0], 32'h2002);
    chk("sh_d0",    32'(wr_d[0]), 32'h34);
    chk("sh_c0",    32'(wr_c[0]), 32'(pc + 1));
    chk("sh_a1",    wr_a[1], 32'h2003);
    chk("sh_d1",    32'(wr_d[1]), 32'h12);
    chk("sh_c1",    32'(wr_c[1]), 32'(pc + 3));

    // SB to IO region waits for UART space
    clear_log();
    io_buffer_full = 1'b1;
    mem_gnt = 1'b1;
    push(OP_SB, 32'h0003_0000, 32'h41);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("io_wait_req", 32'(mem_req), 32'd0);
    end
    chk("io_wait_nwr", 32'(wr_a.size()), 32'd0);
    pc = cyc_n;
    io_buffer_full = 1'b0;
    idle(4);
    chk("io_nwr", 32'(wr_a.size()), 32'd1);
    chk("io_a",   wr_a[0], 32'h0003_0000);
    chk("io_d",   32'(wr_d[0]), 32'h41);
    chk("io_c",   32'(wr_c[0]), 32'(pc + 1));

    // overflow: five SBs with grant held low
    clear_log();
    mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(OP_SB, 32'h100 + 32'(i), 32'h10 + 32'(i));
      if (i == 2) chk("ovf_notfull3", 32'(scb_full), 32'd0);
      if (i == 3) chk("ovf_full4", 32'(scb_full), 32'd1);
      if (i == 4) chk("ovf_err", 32'(err_overflow), 32'd1);
    end
    mem_gnt = 1'b1;
    pc = cyc_n;
    idle(7);
    chk("ovf_nwr", 32'(wr_a.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_addr", wr_a[i], 32'h100 + 32'(i));
      chk("ovf_data", 32'(wr_d[i]), 32'h10 + 32'(i));
      chk("ovf_cyc",  32'(wr_c[i]), 32'(pc + i));
    end
    chk("ovf_err_sticky", 32'(err_overflow), 32'd1);

    // address wrap
    clear_log();
    push(OP_SW, 32'hFFFF_FFFE, 32'h8765_4321);
    idle(8);
    chk("wrap_nwr", 32'(wr_a.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", wr_a[i], s5_a[i]);
      chk("wrap_data", 32'(wr_d[i]), 32'(s5_d[i]));
    end

    // rdy low freezes mid-store and blocks pushes
    clear_log();
    push(OP_SW, 32'h5000, 32'h0403_0201);
    tick();
    tick();
    rdy = 1'b0;
    #1;
    chk("frz_req",  32'(mem_req), 32'd1);
    chk("frz_wr",   32'(mem_wr), 32'd0);
    chk("frz_a",    mem_a, 32'h5001);
    chk("frz_dout", 32'(mem_dout), 32'h02);
    push(OP_SB, 32'h6000, 32'h77);
    idle(2);
    chk("frz_a_hold", mem_a, 32'h5001);
    rdy = 1'b1;
    idle(6);
    chk("frz_nwr", 32'(wr_a.size()), 32'd4);
    chk("frz_a3",  wr_a[3], 32'h5003);
    chk("frz_d3",  32'(wr_d[3]), 32'h04);

    // reset between 2nd and 3rd byte
    clear_log();
    push(OP_SW, 32'h4000, 32'hCAFE_BABE);
    tick();
    tick();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_req",   32'(mem_req), 32'd0);
    chk("mid_rst_wr",    32'(mem_wr), 32'd0);
    chk("mid_rst_a",     mem_a, 32'd0);
    chk("mid_rst_dout",  32'(mem_dout), 32'd0);
    chk("mid_rst_empty", 32'(scb_empty), 32'd1);
    chk("mid_rst_err",   32'(err_overflow), 32'd0);
    chk("mid_rst_nwr",   32'(wr_a.size()), 32'd2);
    tick();
    tick();
    rst = 1'b1;
    idle(5);
    chk("post_rst_nwr", 32'(wr_a.size()), 32'd2);
    push(OP_SB, 32'h7000, 32'h5A);
    idle(4);
    chk("post_rst_nwr2", 32'(wr_a.size()), 32'd3);
    chk("post_rst_a",    wr_a[2], 32'h7000);
    chk("post_rst_d",    32'(wr_d[2]), 32'h5A);
    chk("final_left",    32'(exp_q.size()), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
